// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage PC sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_e;

  localparam int INSTR_BYTES_DEFAULT = 4;

  // Mask that clears the low log2(instr_bytes) bits; instr_bytes must be a power of 2.
  function automatic logic [63:0] align_mask(input int instr_bytes);
    return ~(64'(instr_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority selection of next PC, misalign flag and next state.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  pc_state_e             state,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  pc_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  trap_req,
  input  logic [ADDR_WIDTH-1:0] trap_vector,
  input  logic                  halt_req,
  input  logic                  resume_req,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  misalign,
  output pc_state_e             next_state
);

  localparam logic [63:0]           MASK_FULL = align_mask(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] MASK      = MASK_FULL[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(INSTR_BYTES);

  logic fire;
  logic aligned;

  assign fire    = (state == PC_RUN) && pc_ready;
  assign aligned = (redirect_target & ~MASK) == '0;

  always_comb begin
    next_pc    = pc;
    misalign   = 1'b0;
    next_state = state;
    case (state)
      PC_BOOT: next_state = PC_RUN;
      PC_RUN, PC_HALT: begin
        if (trap_req) begin
          next_pc = trap_vector & MASK;
        end else if (redirect_valid) begin
          if (aligned) next_pc = redirect_target;
          else         misalign = 1'b1;
        end else if (fire) begin
          next_pc = pc + STEP;
        end

        // Trap always lands in RUN, so it beats a simultaneous halt.
        if (state == PC_RUN) begin
          if (halt_req && !trap_req) next_state = PC_HALT;
        end else begin
          if (resume_req || trap_req) next_state = PC_RUN;
        end
      end
      default: next_state = PC_BOOT;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: holds PC, offers it over valid/ready, handles redirect/trap/halt.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                       ADDR_WIDTH_POW = 5,
  parameter int                       ADDR_WIDTH     = 1 << ADDR_WIDTH_POW,
  parameter logic [ADDR_WIDTH-1:0]    RESET_VECTOR   = '0,
  parameter int                       INSTR_BYTES    = INSTR_BYTES_DEFAULT
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  pc_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  trap_req,
  input  logic [ADDR_WIDTH-1:0] trap_vector,
  input  logic                  halt_req,
  input  logic                  resume_req,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  pc_valid,
  output logic                  halted,
  output logic                  misalign_err,
  output logic [ADDR_WIDTH-1:0] misalign_addr
);

  pc_state_e             state_reg;
  pc_state_e             state_next;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  misalign_next;
  logic                  err_reg;
  logic [ADDR_WIDTH-1:0] err_addr_reg;

  pc_next_sel #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_sel (
    .state           (state_reg),
    .pc              (pc_reg),
    .pc_ready        (pc_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .trap_vector     (trap_vector),
    .halt_req        (halt_req),
    .resume_req      (resume_req),
    .next_pc         (pc_next),
    .misalign        (misalign_next),
    .next_state      (state_next)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_reg    <= PC_BOOT;
      pc_reg       <= RESET_VECTOR;
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      err_reg   <= misalign_next;
      if (misalign_next) err_addr_reg <= redirect_target;
    end
  end

  assign pc_out        = pc_reg;
  assign pc_valid      = (state_reg == PC_RUN);
  assign halted        = (state_reg == PC_HALT);
  assign misalign_err  = err_reg;
  assign misalign_addr = err_addr_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: stimulus rows push expectations to a scoreboard queue.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h8000_0000;
  localparam logic [31:0] EA = 32'h8000_1002;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        pc_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        halt_req = 1'b0;
  logic        resume_req = 1'b0;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] misalign_addr;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        hlt;
    logic        err;
    logic [31:0] addr;
  } snap_t;

  typedef struct packed {
    logic        rst;
    logic        ready;
    logic        rv;
    logic [31:0] rt;
    logic        trap;
    logic [31:0] tv;
    logic        halt;
    logic        resume;
    snap_t       exp;
  } stim_t;

  snap_t sb[$];

  pc_sequencer #(
    .ADDR_WIDTH_POW (5),
    .RESET_VECTOR   (32'h8000_0000),
    .INSTR_BYTES    (4)
  ) dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .pc_ready        (pc_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .trap_vector     (trap_vector),
    .halt_req        (halt_req),
    .resume_req      (resume_req),
    .pc_out          (pc_out),
    .pc_valid        (pc_valid),
    .halted          (halted),
    .misalign_err    (misalign_err),
    .misalign_addr   (misalign_addr)
  );

  always #5 clk_in = ~clk_in;

  function automatic stim_t row(input logic rst, input logic ready, input logic rv,
                                input logic [31:0] rt, input logic trap, input logic [31:0] tv,
                                input logic halt, input logic resume, input logic [31:0] epc,
                                input logic ev, input logic eh, input logic ee,
                                input logic [31:0] eaddr);
    stim_t s;
    s.rst = rst; s.ready = ready; s.rv = rv; s.rt = rt; s.trap = trap; s.tv = tv;
    s.halt = halt; s.resume = resume;
    s.exp.pc = epc; s.exp.valid = ev; s.exp.hlt = eh; s.exp.err = ee; s.exp.addr = eaddr;
    return s;
  endfunction

  function automatic snap_t observe();
    snap_t o;
    o.pc = pc_out; o.valid = pc_valid; o.hlt = halted; o.err = misalign_err; o.addr = misalign_addr;
    return o;
  endfunction

  // Drives one row and pushes its expected post-edge outputs to the scoreboard.
  task automatic apply(input stim_t s);
    reset = s.rst; pc_ready = s.ready; redirect_valid = s.rv; redirect_target = s.rt;
    trap_req = s.trap; trap_vector = s.tv; halt_req = s.halt; resume_req = s.resume;
    sb.push_back(s.exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    stim_t rows[$];
    snap_t e, o;
    for (int i = 0; i < 3; i++) rows.push_back(row(1,0,0,0,0,0,0,0, RV,0,0,0,0));
    foreach (rows[i]) begin
      apply(rows[i]); tick(); e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset row %0d: got pc=%h v=%b h=%b e=%b a=%h, expected pc=%h v=%b h=%b e=%b a=%h",
                 i, o.pc, o.valid, o.hlt, o.err, o.addr, e.pc, e.valid, e.hlt, e.err, e.addr);
      end
    end
    // Release: BOOT still holds pc_valid low for this cycle.
    apply(row(0,0,0,0,0,0,0,0, RV,1,0,0,0));
    checks++;
    if (pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_cycle: got pc_valid=%b, expected 0", pc_valid);
    end
    tick(); e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL boot_to_run: got pc=%h v=%b h=%b e=%b a=%h, expected pc=%h v=%b h=%b e=%b a=%h",
               o.pc, o.valid, o.hlt, o.err, o.addr, e.pc, e.valid, e.hlt, e.err, e.addr);
    end
  endtask

  task automatic test_fetch();
    stim_t rows[$];
    snap_t e, o;
    rows.push_back(row(0,1,0,0,0,0,0,0, RV+32'h4,1,0,0,0));
    rows.push_back(row(0,1,0,0,0,0,0,0, RV+32'h8,1,0,0,0));
    rows.push_back(row(0,1,0,0,0,0,0,0, RV+32'hC,1,0,0,0));
    for (int i = 0; i < 4; i++) rows.push_back(row(0,0,0,0,0,0,0,0, RV+32'hC,1,0,0,0));
    foreach (rows[i]) begin
      apply(rows[i]); tick(); e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fetch_backpressure row %0d: got pc=%h v=%b h=%b e=%b a=%h, expected pc=%h v=%b h=%b e=%b a=%h",
                 i, o.pc, o.valid, o.hlt, o.err, o.addr, e.pc, e.valid, e.hlt, e.err, e.addr);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t rows[$];
    snap_t e, o;
    rows.push_back(row(0,0,1,32'h8000_1000,0,0,0,0, 32'h8000_1000,1,0,0,0));
    rows.push_back(row(0,1,1,32'h8000_1002,0,0,0,0, 32'h8000_1000,1,0,1,EA));
    rows.push_back(row(0,0,0,0,0,0,0,0,             32'h8000_1000,1,0,0,EA));
    // Trap beats redirect (aligned or not) and never raises an error.
    rows.push_back(row(0,0,1,32'h8000_2000,1,32'h0000_0103,0,0, 32'h0000_0100,1,0,0,EA));
    rows.push_back(row(0,1,1,32'h8000_2002,1,32'h0000_0206,0,0, 32'h0000_0204,1,0,0,EA));
    foreach (rows[i]) begin
      apply(rows[i]); tick(); e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL redirect_trap row %0d: got pc=%h v=%b h=%b e=%b a=%h, expected pc=%h v=%b h=%b e=%b a=%h",
                 i, o.pc, o.valid, o.hlt, o.err, o.addr, e.pc, e.valid, e.hlt, e.err, e.addr);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t rows[$];
    snap_t e, o;
    rows.push_back(row(0,0,1,32'hFFFF_FFFC,0,0,0,0, 32'hFFFF_FFFC,1,0,0,EA));
    rows.push_back(row(0,1,0,0,0,0,0,0,             32'h0000_0000,1,0,0,EA));
    rows.push_back(row(0,0,0,0,0,0,0,0,             32'h0000_0000,1,0,0,EA));
    foreach (rows[i]) begin
      apply(rows[i]); tick(); e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap row %0d: got pc=%h v=%b h=%b e=%b a=%h, expected pc=%h v=%b h=%b e=%b a=%h",
                 i, o.pc, o.valid, o.hlt, o.err, o.addr, e.pc, e.valid, e.hlt, e.err, e.addr);
      end
    end
  endtask

  task automatic test_halt();
    stim_t rows[$];
    snap_t e, o;
    rows.push_back(row(0,0,1,32'h8000_0010,0,0,0,0, 32'h8000_0010,1,0,0,EA));
    rows.push_back(row(0,1,0,0,0,0,1,0,             32'h8000_0014,0,1,0,EA));
    rows.push_back(row(0,1,0,0,0,0,0,0,             32'h8000_0014,0,1,0,EA));
    rows.push_back(row(0,0,1,32'h8000_0100,0,0,0,0, 32'h8000_0100,0,1,0,EA));
    rows.push_back(row(0,1,0,0,0,0,1,0,             32'h8000_0100,0,1,0,EA));
    rows.push_back(row(0,1,0,0,0,0,0,1,             32'h8000_0100,1,0,0,EA));
    rows.push_back(row(0,0,0,0,0,0,0,1,             32'h8000_0100,1,0,0,EA));
    foreach (rows[i]) begin
      apply(rows[i]); tick(); e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL halt_resume row %0d: got pc=%h v=%b h=%b e=%b a=%h, expected pc=%h v=%b h=%b e=%b a=%h",
                 i, o.pc, o.valid, o.hlt, o.err, o.addr, e.pc, e.valid, e.hlt, e.err, e.addr);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t rows[$];
    snap_t e, o;
    rows.push_back(row(0,1,0,0,1,32'h0000_0200,1,0, 32'h0000_0200,1,0,0,EA));
    rows.push_back(row(0,0,0,0,0,0,1,0,             32'h0000_0200,0,1,0,EA));
    rows.push_back(row(0,0,0,0,1,32'h0000_0307,0,0, 32'h0000_0304,1,0,0,EA));
    rows.push_back(row(0,1,1,32'h8000_0040,0,0,0,0, 32'h8000_0040,1,0,0,EA));
    rows.push_back(row(0,1,0,0,0,0,0,0,             32'h8000_0044,1,0,0,EA));
    foreach (rows[i]) begin
      apply(rows[i]); tick(); e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back row %0d: got pc=%h v=%b h=%b e=%b a=%h, expected pc=%h v=%b h=%b e=%b a=%h",
                 i, o.pc, o.valid, o.hlt, o.err, o.addr, e.pc, e.valid, e.hlt, e.err, e.addr);
      end
    end
  endtask

  task automatic test_reset_in_halt();
    stim_t rows[$];
    snap_t e, o;
    rows.push_back(row(0,0,0,0,0,0,1,0,             32'h8000_0044,0,1,0,EA));
    rows.push_back(row(1,1,1,32'h8000_0800,1,32'h100,0,1, RV,0,0,0,0));
    rows.push_back(row(0,0,0,0,0,0,0,0,             RV,1,0,0,0));
    rows.push_back(row(0,1,0,0,0,0,0,0,             RV+32'h4,1,0,0,0));
    foreach (rows[i]) begin
      apply(rows[i]); tick(); e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_in_halt row %0d: got pc=%h v=%b h=%b e=%b a=%h, expected pc=%h v=%b h=%b e=%b a=%h",
                 i, o.pc, o.valid, o.hlt, o.err, o.addr, e.pc, e.valid, e.hlt, e.err, e.addr);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fetch();
    test_redirect();
    test_wrap();
    test_halt();
    test_back_to_back();
    test_reset_in_halt();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
